// File: rtl/serial_operand_loader.sv
// Parallel-to-serial operand loader: streams an operand pair LSB first with a frame carry.
// Optional subtract mode (invert B, force carry-in) is enabled by defining SERIAL_LOADER_SUB_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// SHIFT | streaming bit cnt of the frame; bit_valid high
module serial_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic             op_sub,
    input  logic             abort,
    output logic             a_bit,
    output logic             b_bit,
    output logic             cin_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             load, advance, finish;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             cin_r;
    logic [CNT_W-1:0] cnt;
    logic             done_r;
    logic [WIDTH-1:0] load_b;
    logic             load_cin;

`ifdef SERIAL_LOADER_SUB_EN
    // Subtract as A + ~B + 1 so a plain serial adder downstream yields A-B.
    assign load_b   = op_sub ? ~op_b : op_b;
    assign load_cin = op_sub ? 1'b1  : carry_in;
`else
    logic unused_sub;
    assign unused_sub = op_sub;
    assign load_b     = op_b;
    assign load_cin   = carry_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !abort) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // abort wins over completing the frame, so no done on an aborted last bit
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                    if (cnt == LAST_CNT) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            cin_r  <= 1'b0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= finish;
            if (load) begin
                sh_a  <= op_a;
                sh_b  <= load_b;
                cin_r <= load_cin;
                cnt   <= '0;
            end else if (advance) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end

    // Serial outputs are gated by state so they read zero between frames.
    assign in_ready  = (state == IDLE);
    assign bit_valid = (state == SHIFT);
    assign a_bit     = bit_valid & sh_a[0];
    assign b_bit     = bit_valid & sh_b[0];
    assign cin_bit   = bit_valid & cin_r;
    assign first_bit = bit_valid && (cnt == '0);
    assign last_bit  = bit_valid && (cnt == LAST_CNT);
    assign done      = done_r;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader: directed frames plus randomized traffic
// compared against a queue-based model of the expected bit stream.
module tb_serial_operand_loader;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         op_sub;
    logic         abort;
    logic         a_bit;
    logic         b_bit;
    logic         cin_bit;
    logic         bit_valid;
    logic         first_bit;
    logic         last_bit;
    logic         done;

    serial_operand_loader #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .op_sub    (op_sub),
        .abort     (abort),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .cin_bit   (cin_bit),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected stream: one queue entry per bit still to be presented.
    bit qa[$];
    bit qb[$];
    bit qc[$];
    bit exp_done = 1'b0;

    int cyc = 0;
    int last_first = -1;
    bit spacing_on = 1'b0;

    logic [W-1:0] cap_a, cap_b, cap_s;
    logic         cap_c;
    int           cap_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_a_bit"},     32'(a_bit),     32'd0);
        chk({tag, "_b_bit"},     32'(b_bit),     32'd0);
        chk({tag, "_cin_bit"},   32'(cin_bit),   32'd0);
        chk({tag, "_first"},     32'(first_bit), 32'd0);
        chk({tag, "_last"},      32'(last_bit),  32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (qa.size() > 0);
        chk("in_ready",  32'(in_ready),  32'(!busy));
        chk("bit_valid", 32'(bit_valid), 32'(busy));
        chk("a_bit",     32'(a_bit),     32'(busy ? qa[0] : 1'b0));
        chk("b_bit",     32'(b_bit),     32'(busy ? qb[0] : 1'b0));
        chk("cin_bit",   32'(cin_bit),   32'(busy ? qc[0] : 1'b0));
        chk("first_bit", 32'(first_bit), 32'(busy && qa.size() == W));
        chk("last_bit",  32'(last_bit),  32'(busy && qa.size() == 1));
        chk("done",      32'(done),      32'(exp_done));
    endtask

    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, input logic sub);
        logic [W-1:0] bl;
        logic         cl;
        bl = b;
        cl = ci;
`ifdef SERIAL_LOADER_SUB_EN
        if (sub) begin
            bl = ~b;
            cl = 1'b1;
        end
`endif
        for (int i = 0; i < W; i++) begin
            qa.push_back(a[i]);
            qb.push_back(bl[i]);
            qc.push_back(cl);
        end
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        qc.delete();
        exp_done = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub, input logic ab);
        bit done_n;
        in_valid = v;
        op_a     = a;
        op_b     = b;
        carry_in = ci;
        op_sub   = sub;
        abort    = ab;
        @(posedge clk);
        done_n = 1'b0;
        if (qa.size() > 0) begin
            if (ab) begin
                model_clear();
            end else begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                void'(qc.pop_front());
                if (qa.size() == 0) done_n = 1'b1;
            end
        end else if (v && !ab) begin
            model_accept(a, b, ci, sub);
        end
        exp_done = done_n;
        cyc++;
        #1;
        check_outputs();
        if (bit_valid) begin
            if (first_bit) begin
                cap_c = cin_bit;
                cap_n = 0;
            end
            cap_a = {a_bit, cap_a[W-1:1]};
            cap_b = {b_bit, cap_b[W-1:1]};
            cap_s = {a_bit ^ b_bit ^ cap_c, cap_s[W-1:1]};
            cap_c = (a_bit & b_bit) | (a_bit & cap_c) | (b_bit & cap_c);
            cap_n++;
        end
        if (spacing_on && first_bit) begin
            if (last_first >= 0) chk("accept_spacing", 32'(cyc - last_first), 32'(W + 1));
            last_first = cyc;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        carry_in = 1'b0;
        op_sub   = 1'b0;
        abort    = 1'b0;
        cap_a = '0; cap_b = '0; cap_s = '0; cap_c = 1'b0; cap_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        #3;
        reset_n = 1'b1;
        idle_steps(2);

        // Directed frame; operands offered during SHIFT must be ignored.
        step(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("a_sequence", 32'(cap_a), 32'h0000_00A5);
        chk("b_sequence", 32'(cap_b), 32'h0000_003C);
        chk("frame_len",  32'(cap_n), 32'(W));

        // Continuous in_valid: accepts are exactly W+1 cycles apart.
        spacing_on = 1'b1;
        last_first = -1;
        for (int i = 0; i < 40; i++) step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
        spacing_on = 1'b0;
        idle_steps(W + 2);

        // Abort while bit 3 is on the wire, then a clean frame.
        step(1'b1, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
        idle_steps(3);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        chk("abort_ready", 32'(in_ready), 32'd1);
        idle_steps(2);
        step(1'b1, 8'h96, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle_steps(W);
        chk("post_abort_a", 32'(cap_a), 32'h0000_0096);
        chk("post_abort_b", 32'(cap_b), 32'h0000_000F);

        // Abort held while idle blocks acceptance.
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        chk("abort_idle_block", 32'(bit_valid), 32'd0);
        idle_steps(1);

        // Subtract request: 0x10 - 0x01 when enabled, plain add otherwise.
        step(1'b1, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        idle_steps(W);
`ifdef SERIAL_LOADER_SUB_EN
        chk("sub_b_stream", 32'(cap_b), 32'h0000_00FE);
        chk("sub_sum",      32'(cap_s), 32'h0000_000F);
`else
        chk("sub_b_stream", 32'(cap_b), 32'h0000_0001);
        chk("sub_sum",      32'(cap_s), 32'h0000_0011);
`endif

        // Reset mid-frame: immediate idle outputs, no done afterwards.
        step(1'b1, 8'hE7, 8'h18, 1'b1, 1'b0, 1'b0);
        idle_steps(3);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        check_idle("midreset");
        @(posedge clk);
        #1;
        check_idle("midreset_edge");
        #3;
        reset_n = 1'b1;
        idle_steps(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 4) != 0), W'($urandom), W'($urandom), 1'($urandom),
                 1'($urandom), 1'(($urandom % 16) == 0));
        end
        idle_steps(W + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_operand_loader.md
SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  parallel operand pair offered.
REQ-005 Port: in_ready  output  1  block can accept an operand pair; high only in IDLE.
REQ-006 Port: op_a  input  WIDTH  parallel operand A.
REQ-007 Port: op_b  input  WIDTH  parallel operand B.
REQ-008 Port: carry_in  input  1  initial carry for the frame.
REQ-009 Port: op_sub  input  1  subtract request; used only when SERIAL_LOADER_SUB_EN is defined.
REQ-010 Port: abort  input  1  synchronous frame cancel.
REQ-011 Port: a_bit  output  1  serial A bit, LSB first.
REQ-012 Port: b_bit  output  1  serial B bit, LSB first.
REQ-013 Port: cin_bit  output  1  frame carry-in, held constant for the whole frame.
REQ-014 Port: bit_valid  output  1  a_bit, b_bit and cin_bit are meaningful this cycle.
REQ-015 Port: first_bit  output  1  current bit is bit 0 of the frame.
REQ-016 Port: last_bit  output  1  current bit is bit WIDTH-1 of the frame.
REQ-017 Port: done  output  1  one-cycle pulse in the cycle after last_bit.

Function
REQ-018 FSM has two states, IDLE and SHIFT; in_ready SHALL equal (state==IDLE).
REQ-019 Accept: when IDLE and in_valid=1 and abort=0 at an edge, op_a, op_b and carry_in SHALL be loaded into shift registers; a bit counter SHALL be cleared; the state SHALL go to SHIFT.
REQ-020 In SHIFT, bit_valid=1; a_bit and b_bit SHALL be the LSBs of the shift registers.
REQ-021 The registers SHALL shift right by one bit per cycle; the counter SHALL increment 0..WIDTH-1.
REQ-022 first_bit=1 only when counter==0; last_bit=1 only when counter==WIDTH-1; both are zero in IDLE.
REQ-023 At the edge ending counter==WIDTH-1, the state SHALL go to IDLE; done SHALL be 1 for exactly the next cycle.
REQ-024 Frame length is exactly WIDTH bit_valid cycles; minimum accept-to-accept spacing is WIDTH+1 cycles.
REQ-025 in_valid during SHIFT SHALL be ignored; no operand is captured until in_ready=1.
REQ-026 abort=1 in SHIFT SHALL force IDLE at the next edge; bit_valid and first_bit/last_bit SHALL be 0 after that edge; done SHALL NOT pulse.
REQ-027 abort=1 in IDLE SHALL block acceptance that cycle, even if in_valid=1; abort has priority.
REQ-028 a_bit, b_bit and cin_bit SHALL be 0 whenever bit_valid=0.
REQ-029 All outputs SHALL be registered or decoded from state only; there is no combinational path from any input to any output.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, clear the shift registers and counter, and drive a_bit, b_bit, cin_bit, bit_valid, first_bit, last_bit and done to 0; in_ready SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL discard the frame without pulsing done.

Configuration
REQ-032 Macro SERIAL_LOADER_SUB_EN: when defined and op_sub=1 at accept, the block SHALL load ~op_b and SHALL set cin_bit to 1 for the frame. This gives A-B in two's complement downstream.
REQ-033 Without SERIAL_LOADER_SUB_EN, op_sub SHALL be ignored; operands and carry_in are loaded unmodified.

Verification
REQ-034 After reset release, check in_ready=1 and all other outputs 0; assert reset_n=0 mid-frame and check immediate return to these values with no done pulse.
REQ-035 WIDTH=8, op_a=8'hA5, op_b=8'h3C, carry_in=1 -> a_bit sequence 1,0,1,0,0,1,0,1 and b_bit sequence 0,0,1,1,1,1,0,0; cin_bit=1 for the 8 cycles; first_bit on cycle 1 only; last_bit on cycle 8 only; done on cycle 9.
REQ-036 Hold in_valid=1 continuously with changing operands -> accepts are spaced 9 cycles apart; operands presented during SHIFT are never captured.
REQ-037 Assert abort at bit 3 of a frame -> IDLE next cycle, bit_valid=0, no done pulse, in_ready=1; next accept streams correctly.
REQ-038 With SERIAL_LOADER_SUB_EN defined, op_a=8'h10, op_b=8'h01, op_sub=1 -> b_bit streams 8'hFE LSB first and cin_bit=1; a downstream serial adder produces 8'h0F. Without the macro, the same stimulus streams 8'h01.
